// File: rtl/nyq_pkg.sv
`default_nettype none
//==============================================================================
// nyq_pkg : shared FSM encoding and counter widths for the Nyquist MAC sequencer
// Rev 1.0
//==============================================================================
package nyq_pkg;

    localparam int unsigned DROP_CNT_WIDTH = 8;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_RUN     = 3'd2;
    localparam logic [2:0] c_CAPTURE = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = c_IDLE,
        ST_CLEAR   = c_CLEAR,
        ST_RUN     = c_RUN,
        ST_CAPTURE = c_CAPTURE,
        ST_DONE    = c_DONE
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/nyq_mac_seq_if.sv
`default_nettype none
//==============================================================================
// nyq_mac_seq_if : sample-write, request/result and MAC/memory signals of the
//                  sequencer; drop_cnt exists only with NYQ_SEQ_DROP_CNT_EN.
// Rev 1.0
//==============================================================================
interface nyq_mac_seq_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  samp_wr_en;
    logic [ADDR_WIDTH-1:0] samp_wr_addr;
    logic                  samp_wr_ack;
    logic [ADDR_WIDTH:0]   tap_cnt;
    logic                  start;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] coef_addr;
    logic [ADDR_WIDTH-1:0] samp_addr;
    logic                  mac_clr;
    logic                  mac_wr_en;
    logic [WIDTH-1:0]      mac_out;
    logic [WIDTH-1:0]      result;
    logic                  valid;
    logic                  ack;
`ifdef NYQ_SEQ_DROP_CNT_EN
    logic [nyq_pkg::DROP_CNT_WIDTH-1:0] drop_cnt;

    modport slave (
        input  samp_wr_en, tap_cnt, start, mac_out, ack,
        output samp_wr_addr, samp_wr_ack, ready, coef_addr, samp_addr,
               mac_clr, mac_wr_en, result, valid, drop_cnt
    );
    modport master (
        output samp_wr_en, tap_cnt, start, mac_out, ack,
        input  samp_wr_addr, samp_wr_ack, ready, coef_addr, samp_addr,
               mac_clr, mac_wr_en, result, valid, drop_cnt
    );
`else
    modport slave (
        input  samp_wr_en, tap_cnt, start, mac_out, ack,
        output samp_wr_addr, samp_wr_ack, ready, coef_addr, samp_addr,
               mac_clr, mac_wr_en, result, valid
    );
    modport master (
        output samp_wr_en, tap_cnt, start, mac_out, ack,
        input  samp_wr_addr, samp_wr_ack, ready, coef_addr, samp_addr,
               mac_clr, mac_wr_en, result, valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/nyq_ring_ptr.sv
`default_nettype none
//==============================================================================
// nyq_ring_ptr : wrapping pointer over a power-of-two ring, advances on i_inc
// Rev 1.0
//==============================================================================
module nyq_ring_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_inc,
    output logic      [ADDR_WIDTH-1:0] o_ptr
);
    logic [ADDR_WIDTH-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;
endmodule
`default_nettype wire

// File: rtl/nyq_mac_seq.sv
`default_nettype none
//==============================================================================
// nyq_mac_seq : sequences one FIR dot product per request through an external
//               MAC; optional dropped-write counter under NYQ_SEQ_DROP_CNT_EN.
// Rev 1.0
//==============================================================================
module nyq_mac_seq
    import nyq_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_TAPS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    nyq_mac_seq_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] c_NUM_TAPS = NUM_TAPS[ADDR_WIDTH:0];

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [ADDR_WIDTH:0]   r_taps;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [WIDTH-1:0]      r_result;
    logic [ADDR_WIDTH-1:0] w_wr_ptr;
    logic [ADDR_WIDTH:0]   w_taps_clamped;
    logic                  w_wr_ok;
    logic                  w_wr_ack;
    logic                  w_run_last;
    logic                  w_mac_clr;
    logic                  w_mac_wr_en;

    assign w_wr_ok        = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_wr_ack       = bus.samp_wr_en && w_wr_ok;
    assign w_taps_clamped = (bus.tap_cnt > c_NUM_TAPS) ? c_NUM_TAPS : bus.tap_cnt;
    assign w_run_last     = (r_cnt == r_taps - (ADDR_WIDTH+1)'(1));

    nyq_ring_ptr #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_wr_ack),
        .o_ptr (w_wr_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mac_clr   = 1'b0;
        w_mac_wr_en = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_mac_clr   = 1'b1;
                w_mac_wr_en = 1'b1;
                w_state_nxt = (r_taps == '0) ? ST_CAPTURE : ST_RUN;
            end
            ST_RUN: begin
                w_mac_wr_en = 1'b1;
                if (w_run_last) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.ack) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // r_k is the tap whose addresses are on the bus; it runs one tap ahead of
    // the MAC because the memories add a cycle of read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taps   <= '0;
            r_cnt    <= '0;
            r_k      <= '0;
            r_base   <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_taps <= w_taps_clamped;
                        r_cnt  <= '0;
                        r_k    <= '0;
                        r_base <= w_wr_ack ? w_wr_ptr : w_wr_ptr - ADDR_WIDTH'(1);
                    end
                end
                ST_CLEAR: begin
                    if (r_taps > (ADDR_WIDTH+1)'(1)) r_k <= ADDR_WIDTH'(1);
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
                    if (r_cnt + (ADDR_WIDTH+1)'(2) < r_taps) r_k <= r_k + ADDR_WIDTH'(1);
                end
                ST_CAPTURE: begin
                    r_result <= (r_taps == '0) ? '0 : bus.mac_out;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NYQ_SEQ_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if ((r_state == ST_DONE) && bus.ack) begin
            r_drop_cnt <= '0;
        end else if (bus.samp_wr_en && !w_wr_ok && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`endif

    assign bus.samp_wr_addr = w_wr_ptr;
    assign bus.samp_wr_ack  = w_wr_ack;
    assign bus.ready        = (r_state == ST_IDLE);
    assign bus.valid        = (r_state == ST_DONE);
    assign bus.coef_addr    = r_k;
    assign bus.samp_addr    = r_base - r_k;
    assign bus.mac_clr      = w_mac_clr;
    assign bus.mac_wr_en    = w_mac_wr_en;
    assign bus.result       = r_result;
endmodule
`default_nettype wire

// File: tb/tb_nyq_mac_seq.sv
`default_nettype none
//==============================================================================
// tb_nyq_mac_seq : vector table, directed corner sequences and random requests
//                  checked against a dot-product model with memory/MAC stand-ins
// Rev 1.0
//==============================================================================
module tb_nyq_mac_seq;
    localparam int WIDTH      = 16;
    localparam int NUM_TAPS   = 16;
    localparam int ADDR_WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nyq_mac_seq_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    nyq_mac_seq #(
        .WIDTH      (WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External memories (1-cycle read) and MAC with clear priority
    logic [WIDTH-1:0] coef_mem [NUM_TAPS];
    logic [WIDTH-1:0] samp_mem [NUM_TAPS];
    logic [WIDTH-1:0] coef_q, samp_q, wr_data;
    logic [WIDTH-1:0] acc = 16'h5a5a;

    always @(posedge clk) begin
        coef_q <= coef_mem[bus.coef_addr];
        samp_q <= samp_mem[bus.samp_addr];
        if (bus.mac_wr_en) acc <= bus.mac_clr ? '0 : acc + coef_q * samp_q;
        if (bus.samp_wr_en && bus.samp_wr_ack) samp_mem[bus.samp_wr_addr] <= wr_data;
    end
    assign bus.mac_out = acc;

    // Reference model: ring of written samples, coefficient k is k+1
    logic [WIDTH-1:0] m_buf [NUM_TAPS];
    int m_wptr = 0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [WIDTH-1:0] m_dot(input int taps, input int newest);
        int unsigned s;
        s = 0;
        for (int k = 0; k < taps; k++) s += (k + 1) * m_buf[(newest - k) & (NUM_TAPS - 1)];
        return s[WIDTH-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_sample(input logic [WIDTH-1:0] v, input bit exp_acc);
        @(posedge clk); #1;
        bus.samp_wr_en = 1'b1;
        wr_data        = v;
        @(negedge clk);
        check("wr_ack", bus.samp_wr_ack, exp_acc);
        if (exp_acc) begin
            m_buf[m_wptr] = v;
            m_wptr = (m_wptr + 1) % NUM_TAPS;
        end
        @(posedge clk); #1;
        bus.samp_wr_en = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_wr_addr", bus.samp_wr_addr, 0);
        check("rst_coef_addr", bus.coef_addr, 0);
        check("rst_samp_addr", bus.samp_addr, 0);
        check("rst_result", bus.result, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_mac_ctl", {bus.mac_clr, bus.mac_wr_en}, 0);
        check("rst_ready", bus.ready, 1);
`ifdef NYQ_SEQ_DROP_CNT_EN
        check("rst_drop_cnt", bus.drop_cnt, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n  = 1'b1;
        m_wptr = 0;
    endtask

    // One request: start, watch the address/MAC trace, wait for Valid, stall, ack
    task automatic run_op(input logic [ADDR_WIDTH:0] tap, input bit wr_st, input int exp_lat,
                          input int stall, input int drop_cyc);
        int t, newest, cyc, wrens, bad_cyc, last_tap;
        bit seen, tr_ok, hold_ok;
        logic [WIDTH-1:0] exp_res, res_hold;
        logic [ADDR_WIDTH-1:0] exp_wp;
        t = (int'(tap) > NUM_TAPS) ? NUM_TAPS : int'(tap);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.tap_cnt    = tap;
        bus.samp_wr_en = wr_st;
        wr_data        = WIDTH'($urandom);
        @(negedge clk);
        check("ready_at_start", bus.ready, 1);
        if (wr_st) begin
            check("wr_ack_with_start", bus.samp_wr_ack, 1);
            m_buf[m_wptr] = wr_data;
            m_wptr = (m_wptr + 1) % NUM_TAPS;
        end
        newest   = (m_wptr + NUM_TAPS - 1) % NUM_TAPS;
        exp_res  = m_dot(t, newest);
        exp_wp   = ADDR_WIDTH'(m_wptr);
        last_tap = (t > 0) ? t : 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; seen = 0; wrens = 0; tr_ok = 1; bad_cyc = 0;
        while (cyc <= 40 && !seen) begin
            bus.samp_wr_en = (cyc == drop_cyc);
            bus.ack        = (cyc == 2);
            wr_data        = WIDTH'($urandom);
            @(negedge clk);
            if (cyc == drop_cyc) check("drop_ack", bus.samp_wr_ack, 0);
            if (bus.mac_wr_en) wrens++;
            if (bus.valid) begin
                seen = 1;
            end else begin
                if ((bus.mac_clr !== (cyc == 1)) || (bus.ready !== 1'b0) ||
                    (cyc <= last_tap && (bus.coef_addr !== ADDR_WIDTH'(cyc - 1) ||
                     bus.samp_addr !== ADDR_WIDTH'((newest - (cyc - 1)) & (NUM_TAPS - 1))))) begin
                    if (tr_ok) bad_cyc = cyc;
                    tr_ok = 0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.samp_wr_en = 1'b0;
        bus.ack        = 1'b0;
        check("valid_latency", seen ? cyc : -1, exp_lat);
        check("result", bus.result, exp_res);
        check("mac_wr_en_cycles", wrens, t + 1);
        check($sformatf("trace_bad_cycle_%0d", bad_cyc), tr_ok, 1);
        check("wr_ptr_after_op", bus.samp_wr_addr, exp_wp);
`ifdef NYQ_SEQ_DROP_CNT_EN
        check("drop_cnt_done", bus.drop_cnt, (drop_cyc != 0) ? 1 : 0);
`endif
        res_hold = bus.result;
        hold_ok  = 1;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            bus.start = 1'b1;
            @(negedge clk);
            if (bus.valid !== 1'b1 || bus.result !== res_hold || bus.ready !== 1'b0) hold_ok = 0;
        end
        if (stall > 0) check("stall_hold", hold_ok, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.ack   = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        check("ready_after_ack", {bus.ready, bus.valid}, 2'b10);
`ifdef NYQ_SEQ_DROP_CNT_EN
        check("drop_cnt_after_ack", bus.drop_cnt, 0);
`endif
    endtask

    typedef struct {
        logic [ADDR_WIDTH:0] tap;
        bit                  wr_st;
        int                  stall;
        int                  drop_cyc;
        int                  exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_TAPS; k++) coef_mem[k] = WIDTH'(k + 1);
        vecs[0] = '{5'd16, 1'b0, 0,  0, 19};
        vecs[1] = '{5'd0,  1'b0, 0,  0, 3};
        vecs[2] = '{5'd20, 1'b0, 0,  0, 19};
        vecs[3] = '{5'd1,  1'b1, 0,  0, 4};
        vecs[4] = '{5'd2,  1'b1, 0,  0, 5};
        vecs[5] = '{5'd7,  1'b0, 10, 0, 10};
        vecs[6] = '{5'd8,  1'b0, 0,  4, 11};
        vecs[7] = '{5'd31, 1'b1, 3,  0, 19};
        vecs[8] = '{5'd3,  1'b0, 0,  2, 6};
        vecs[9] = '{5'd0,  1'b1, 2,  1, 3};
        bus.samp_wr_en = 1'b0;
        bus.tap_cnt    = '0;
        bus.start      = 1'b0;
        bus.ack        = 1'b0;
        wr_data        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks();
        rst_n = 1'b1;

        // Four fresh samples against coefficients 1..4
        for (int i = 1; i <= 4; i++) write_sample(WIDTH'(i), 1'b1);
        run_op(5'd4, 1'b0, 7, 0, 0);
        check("t1_result_20", bus.result, 20);

        for (int i = 0; i < 12; i++) write_sample(WIDTH'($urandom), 1'b1);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].tap, vecs[i].wr_st, vecs[i].exp_lat, vecs[i].stall, vecs[i].drop_cyc);

        // Ring wrap: 18 writes from reset leave the pointer at 2
        do_reset();
        for (int i = 0; i < 18; i++) write_sample(WIDTH'($urandom), 1'b1);
        check("wr_ptr_after_18", bus.samp_wr_addr, 2);
        run_op(5'd16, 1'b0, 19, 0, 0);

        // Asynchronous reset in RUN tap 5, then a clean request from a stale MAC
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.tap_cnt = 5'd16;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("mid_run_wr_en", bus.mac_wr_en, 1);
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n  = 1'b1;
        m_wptr = 0;
        run_op(5'd5, 1'b1, 8, 0, 0);

        for (int i = 0; i < 10; i++) begin
            int nw, tp;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) write_sample(WIDTH'($urandom), 1'b1);
            tp = $urandom_range(0, 31);
            run_op(5'(tp), 1'($urandom_range(0, 1)), ((tp > NUM_TAPS) ? NUM_TAPS : tp) + 3,
                   $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
